// File: rtl/phat_fft_sched_if.sv
// Signal bundle between the xcorr FIFOs, the shared FFT core and phat_fft_sched.
// master = scheduler side, slave = FIFO/FFT/bin-RAM side.
interface phat_fft_sched_if #(
  parameter int NCH       = 4,
  parameter int FRAME_LEN = 64
);
  localparam int CW = $clog2(NCH);
  localparam int AW = $clog2(FRAME_LEN);

  logic [NCH-1:0] ch_req;
  logic [NCH-1:0] ch_rd_en;
  logic [CW-1:0]  ch_sel;
  logic           ch_pad;
  logic           fft_start;
  logic           fft_opd;
  logic           fft_eoud;
  logic [CW-1:0]  out_ch;
  logic [AW-1:0]  out_addr;
  logic           out_we;
  logic           frame_done;
  logic [CW-1:0]  done_ch;
  logic           busy;
  logic           err_timeout;

  modport master (
    input  ch_req, fft_opd, fft_eoud,
    output ch_rd_en, ch_sel, ch_pad, fft_start, out_ch, out_addr, out_we,
           frame_done, done_ch, busy, err_timeout
  );

  modport slave (
    output ch_req, fft_opd, fft_eoud,
    input  ch_rd_en, ch_sel, ch_pad, fft_start, out_ch, out_addr, out_we,
           frame_done, done_ch, busy, err_timeout
  );
endinterface

// File: rtl/phat_fft_sched.sv
// Shared-FFT scheduler: arbitrates xcorr FIFOs onto one FFT core and tags its output.
// Define PHAT_SCHED_FIXED_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module phat_fft_sched #(
  parameter int NCH       = 4,
  parameter int FRAME_LEN = 64,
  parameter int FILL_LEN  = 33,
  parameter int TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             rst,
  phat_fft_sched_if.master bus
);
  localparam int CW   = $clog2(NCH);
  localparam int AW   = $clog2(FRAME_LEN);
  localparam int CNTW = AW + 1;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam bit PAD_TAIL = (FILL_LEN < FRAME_LEN);
  localparam logic [NCH-1:0] ONE_HOT0 = {{(NCH-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARB   = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_FEED  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]      state;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   pick;
  logic            pick_vld;
  logic [CW-1:0]   rr_idx;
  logic [CNTW-1:0] feed_cnt;
  logic [AW-1:0]   addr_cnt;
  logic [TW-1:0]   wait_cnt;
  logic            pad_tail;
  logic            out_we_q;
  logic [AW-1:0]   out_addr_q;
  logic            err_q;
  logic            to_hit;

  // eoud wins over a timeout landing in the same cycle
  assign to_hit = (state == S_DRAIN) && !bus.fft_eoud && (wait_cnt == TW'(TIMEOUT));

`ifdef PHAT_SCHED_FIXED_PRIO_EN
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      rr_idx = CW'(i);
      if (bus.ch_req[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end
`else
  logic [CW-1:0] last_grant;

  // walk from the farthest candidate to the nearest so the nearest after last_grant wins
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    rr_idx   = '0;
    for (int i = NCH; i >= 1; i--) begin
      rr_idx = CW'((int'(last_grant) + i) % NCH);
      if (bus.ch_req[rr_idx]) begin
        pick     = rr_idx;
        pick_vld = 1'b1;
      end
    end
  end

  // a timed-out channel still gives up its turn
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= CW'(NCH - 1);
    else if ((state == S_DONE) || to_hit)
      last_grant <= grant;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      grant      <= '0;
      feed_cnt   <= '0;
      addr_cnt   <= '0;
      wait_cnt   <= '0;
      pad_tail   <= 1'b0;
      out_we_q   <= 1'b0;
      out_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      out_we_q <= 1'b0;
      pad_tail <= 1'b0;
      case (state)
        S_IDLE: if (|bus.ch_req) state <= S_ARB;
        S_ARB: begin
          if (pick_vld) begin
            grant <= pick;
            state <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          feed_cnt <= '0;
          state    <= S_FEED;
        end
        S_FEED: begin
          feed_cnt <= feed_cnt + 1'b1;
          if (feed_cnt == CNTW'(FRAME_LEN - 1)) begin
            state    <= S_DRAIN;
            addr_cnt <= '0;
            wait_cnt <= '0;
            // last read sample lands one cycle after FEED ends
            pad_tail <= PAD_TAIL;
          end
        end
        S_DRAIN: begin
          if (bus.fft_opd) begin
            out_we_q   <= 1'b1;
            out_addr_q <= addr_cnt;
            addr_cnt   <= addr_cnt + 1'b1;
          end
          if (bus.fft_eoud) begin
            state <= S_DONE;
          end else if (to_hit) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // outputs decode only registered state, so no input reaches an output combinationally
  assign bus.ch_rd_en    = ((state == S_FEED) && (feed_cnt < CNTW'(FILL_LEN))) ? (ONE_HOT0 << grant) : '0;
  assign bus.ch_pad      = ((state == S_FEED) && (feed_cnt > CNTW'(FILL_LEN))) || pad_tail;
  assign bus.ch_sel      = grant;
  assign bus.fft_start   = (state == S_START);
  assign bus.out_ch      = grant;
  assign bus.out_addr    = out_addr_q;
  assign bus.out_we      = out_we_q;
  assign bus.frame_done  = (state == S_DONE);
  assign bus.done_ch     = (state == S_DONE) ? grant : '0;
  assign bus.busy        = (state != S_IDLE);
  assign bus.err_timeout = err_q;
endmodule
